instruction_fetch_stage: RTL

Requester side of the combinational program-memory read interface. Holds the program counter and drives the byte address to program memory. Captures the returned instruction into the IF/ID pipeline register. Handles PC sequencing, branch/jump/jr redirects, stall, flush, fetch-fault detection and a retired-fetch counter.

---
 rtl/instruction_fetch_stage.sv | 117 +++++++++++
 1 files changed

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the program-memory address and
// registers the returned instruction into the IF/ID pipeline register.
module instruction_fetch_stage #(
   parameter int unsigned           DATA_WIDTH   = 32,
   parameter int unsigned           MEMORY_DEPTH = 256,
   parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Stall_i,
   input  logic                  Flush_i,
   input  logic [1:0]            PCSrc_i,
   input  logic [DATA_WIDTH-1:0] BranchTarget_i,
   input  logic [25:0]           JumpIndex_i,
   input  logic [DATA_WIDTH-1:0] RegTarget_i,
   output logic [DATA_WIDTH-1:0] Address_o,
   input  logic [DATA_WIDTH-1:0] Instruction_i,
   output logic [DATA_WIDTH-1:0] IFID_Instruction_o,
   output logic [DATA_WIDTH-1:0] IFID_PCPlus4_o,
   output logic                  IFID_Valid_o,
   output logic                  FetchFault_o,
   output logic [DATA_WIDTH-1:0] FetchCount_o
);

   typedef enum logic [1:0] {
      SRC_SEQ    = 2'b00,
      SRC_BRANCH = 2'b01,
      SRC_JUMP   = 2'b10,
      SRC_REG    = 2'b11
   } pc_src_e;

   localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
   localparam logic [DATA_WIDTH-1:0] COUNT_ONE  = DATA_WIDTH'(1);
   localparam logic [DATA_WIDTH-3:0] WORD_LIMIT = (DATA_WIDTH-2)'(MEMORY_DEPTH);

   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic [DATA_WIDTH-1:0] pcplus4_q, pcplus4_d;
   logic                  valid_q, valid_d;
   logic                  fault_q, fault_d;
   logic [DATA_WIDTH-1:0] count_q, count_d;

   logic [DATA_WIDTH-1:0] pc_plus4;
   logic [DATA_WIDTH-1:0] jump_target;
   logic [DATA_WIDTH-1:0] next_pc;
   logic                  pc_fault;

   always_comb begin
      pc_plus4    = pc_q + PC_STEP;
      jump_target = {pc_plus4[DATA_WIDTH-1:28], JumpIndex_i, 2'b00};

      case (pc_src_e'(PCSrc_i))
         SRC_SEQ:    next_pc = pc_plus4;
         SRC_BRANCH: next_pc = BranchTarget_i;
         SRC_JUMP:   next_pc = jump_target;
         SRC_REG:    next_pc = RegTarget_i;
         default:    next_pc = pc_plus4;
      endcase

      pc_fault = (pc_q[1:0] != 2'b00) || (pc_q[DATA_WIDTH-1:2] >= WORD_LIMIT);
   end

   // Flush outranks stall so a redirect is never lost behind a hazard.
   always_comb begin
      pc_d      = pc_q;
      instr_d   = instr_q;
      pcplus4_d = pcplus4_q;
      valid_d   = valid_q;
      fault_d   = fault_q;
      count_d   = count_q;

      if (Flush_i) begin
         pc_d      = next_pc;
         instr_d   = '0;
         pcplus4_d = '0;
         valid_d   = 1'b0;
      end else if (!Stall_i) begin
         pc_d      = next_pc;
         pcplus4_d = pc_plus4;
         if (pc_fault) begin
            instr_d = '0;
            valid_d = 1'b0;
            fault_d = 1'b1;
         end else begin
            instr_d = Instruction_i;
            valid_d = 1'b1;
            count_d = count_q + COUNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q      <= RESET_PC;
         instr_q   <= '0;
         pcplus4_q <= '0;
         valid_q   <= 1'b0;
         fault_q   <= 1'b0;
         count_q   <= '0;
      end else begin
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         pcplus4_q <= pcplus4_d;
         valid_q   <= valid_d;
         fault_q   <= fault_d;
         count_q   <= count_d;
      end
   end

   assign Address_o          = pc_q;
   assign IFID_Instruction_o = instr_q;
   assign IFID_PCPlus4_o     = pcplus4_q;
   assign IFID_Valid_o       = valid_q;
   assign FetchFault_o       = fault_q;
   assign FetchCount_o       = count_q;

endmodule
